cache_axi_bridge: RTL and testbench
===================================

CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 clk  input  1  clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 req  input  1  cache request (cache I_req/D_req side).
REQ-004 addr  input  32  request byte address.
REQ-005 write  input  1  1=store, 0=load.
REQ-006 wdata_in  input  32  store data, already lane-aligned by the cache.
REQ-007 type  input  `CACHE_TYPE_BITS  `CACHE_BYTE/`CACHE_HWORD/`CACHE_WORD/`CACHE_BYTE_U/`CACHE_HWORD_U.
REQ-008 rdata_out  output  32  returned load word.
REQ-009 wait_o  output  1  busy indication to the cache.
REQ-010 araddr/arsize/arvalid  output  32/3/1  AXI read address; arready input 1.
REQ-011 rdata/rresp/rvalid  input  32/2/1  AXI read data; rready output 1.
REQ-012 awaddr/awsize/awvalid  output  32/3/1  AXI write address; awready input 1.
REQ-013 wdata/wstrb/wlast/wvalid  output  32/4/1/1  AXI write data; wready input 1.
REQ-014 bresp/bvalid  input  2/1  AXI write response; bready output 1.
REQ-015 bus_err  output  1  sticky error flag (present only with BRIDGE_ERR_LATCH_EN).
REQ-016 err_addr  output  32  address of first errored transfer (only with BRIDGE_ERR_LATCH_EN).

Function
REQ-017 FSM states IDLE, RADDR, RDATA, WREQ, WRESP, DONE; single outstanding transfer, single-beat (len 0) only.
REQ-018 IDLE with req=1: latch addr, write, wdata_in, type; go RADDR if write=0, else WREQ.
REQ-019 wait_o = 1 in IDLE when req=1 and in RADDR/RDATA/WREQ/WRESP; wait_o = 0 in DONE and in IDLE when req=0.
REQ-020 RADDR: arvalid=1 with latched addr; stays until arready; then RDATA.
REQ-021 RDATA: rready=1; on rvalid capture rdata into rdata_out register, go DONE.
REQ-022 Load araddr = {addr[31:2],2'b00}, arsize=2 regardless of type; sub-word extraction is the cache's job.
REQ-023 WREQ: awvalid and wvalid both asserted first cycle; each deasserts independently after its handshake; both handshakes, in either order or same cycle, required before WRESP.
REQ-024 Store awaddr = latched addr; awsize 0/1/2 for byte/hword/word types; wlast=1.
REQ-025 wstrb: byte -> 4'b0001<<addr[1:0]; hword -> 4'b0011<<{addr[1],1'b0}; word -> 4'hF; other type codes -> 4'h0.
REQ-026 WRESP: bready=1; on bvalid go DONE.
REQ-027 DONE lasts exactly one cycle, always returns to IDLE; rdata_out holds until next load completes.
REQ-028 Minimal load latency: req sampled cycle 0, arvalid cycle 1, rvalid cycle 2 (zero-wait slave), wait_o=0 with valid rdata_out cycle 3.
REQ-029 req deasserted mid-transfer: transfer completes on AXI (no valid dropped before handshake); DONE still taken; result ignored.
REQ-030 AXI valids never depend combinationally on ready inputs; valid/address/data stable until handshake.
REQ-031 rresp/bresp non-OKAY: transfer still completes normally through DONE.

Reset
REQ-032 rst=1: state IDLE, all valids/readies 0, rdata_out 0, wait_o 0, latched request 0, bus_err 0, err_addr 0.
REQ-033 rst mid-transfer aborts immediately to IDLE; no recovery of the outstanding AXI transfer is attempted.

Configuration
REQ-034 BRIDGE_ERR_LATCH_EN defined: bus_err set on first rresp/bresp != 2'b00 and held until rst; err_addr captures that transfer's address once.
REQ-035 BRIDGE_ERR_LATCH_EN undefined: bus_err and err_addr ports and logic absent; responses ignored.

Verification
REQ-036 Load addr=0x0000_1008, arready=1, rvalid next cycle rdata=0xDEAD_BEEF -> araddr=0x0000_1008, arsize=2, rdata_out=0xDEAD_BEEF with wait_o=0 at cycle 3.
REQ-037 Byte store addr=0x0000_2003, type=`CACHE_BYTE, wdata_in=0xAA00_0000 -> awsize=0, wstrb=4'b1000, wdata=0xAA00_0000.
REQ-038 Word store, wready 2 cycles before awready -> wvalid drops after W handshake, awvalid held, single DONE cycle after bvalid.
REQ-039 Load with arready low 5 cycles -> arvalid/araddr stable all 5 cycles, wait_o=1 throughout.
REQ-040 rst asserted during RDATA -> same cycle rready=0, wait_o=0, state IDLE; next req starts clean transfer.
REQ-041 (BRIDGE_ERR_LATCH_EN) store bresp=2'b10 at addr 0x0000_3000, then error-free load -> bus_err=1, err_addr=0x0000_3000 retained.

Source files
------------

// File: rtl/cache_axi_bridge.sv
// rtl/cache_axi_bridge.sv - single-outstanding cache-to-AXI bridge; optional error latch via BRIDGE_ERR_LATCH_EN
// Access-type codes are shared with the cache; the guards let the cache's own definitions win.

`ifndef CACHE_TYPE_BITS
`define CACHE_TYPE_BITS 3
`endif
`ifndef CACHE_BYTE
`define CACHE_BYTE    3'd0
`endif
`ifndef CACHE_HWORD
`define CACHE_HWORD   3'd1
`endif
`ifndef CACHE_WORD
`define CACHE_WORD    3'd2
`endif
`ifndef CACHE_BYTE_U
`define CACHE_BYTE_U  3'd3
`endif
`ifndef CACHE_HWORD_U
`define CACHE_HWORD_U 3'd4
`endif

module cache_axi_bridge (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req,
    input  logic [31:0]                 addr,
    input  logic                        write,
    input  logic [31:0]                 wdata_in,
    input  logic [`CACHE_TYPE_BITS-1:0] cache_type,
    output logic [31:0]                 rdata_out,
    output logic                        wait_o,
    output logic [31:0]                 araddr,
    output logic [2:0]                  arsize,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [31:0]                 rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rvalid,
    output logic                        rready,
    output logic [31:0]                 awaddr,
    output logic [2:0]                  awsize,
    output logic                        awvalid,
    input  logic                        awready,
    output logic [31:0]                 wdata,
    output logic [3:0]                  wstrb,
    output logic                        wlast,
    output logic                        wvalid,
    input  logic                        wready,
    input  logic [1:0]                  bresp,
    input  logic                        bvalid,
    output logic                        bready
`ifdef BRIDGE_ERR_LATCH_EN
    ,
    output logic                        bus_err,
    output logic [31:0]                 err_addr
`endif
);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;

    state_t                        state;
    logic [31:0]                   addr_q;
    logic                          write_q;
    logic [31:0]                   wdata_q;
    logic [`CACHE_TYPE_BITS-1:0]   type_q;

    function automatic logic [3:0] strb_of(input logic [`CACHE_TYPE_BITS-1:0] t,
                                           input logic [1:0] a);
        case (t)
            `CACHE_BYTE:  strb_of = 4'b0001 << a;
            `CACHE_HWORD: strb_of = 4'b0011 << {a[1], 1'b0};
            `CACHE_WORD:  strb_of = 4'hF;
            default:      strb_of = 4'h0;
        endcase
    endfunction

    function automatic logic [2:0] size_of(input logic [`CACHE_TYPE_BITS-1:0] t);
        case (t)
            `CACHE_BYTE:  size_of = 3'd0;
            `CACHE_HWORD: size_of = 3'd1;
            default:      size_of = 3'd2;
        endcase
    endfunction

    // Bus address/data fields come straight from the latched request, so they are stable until handshake.
    assign araddr = {addr_q[31:2], 2'b00};
    assign arsize = 3'd2;
    assign awaddr = addr_q;
    assign awsize = size_of(type_q);
    assign wdata  = wdata_q;
    assign wstrb  = write_q ? strb_of(type_q, addr_q[1:0]) : 4'h0;
    assign wlast  = 1'b1;

    assign wait_o = !rst && ((state == IDLE && req) ||
                             (state != IDLE && state != DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            rdata_out <= 32'h0;
            addr_q    <= 32'h0;
            write_q   <= 1'b0;
            wdata_q   <= 32'h0;
            type_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        write_q <= write;
                        wdata_q <= wdata_in;
                        type_q  <= cache_type;
                        if (write) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WREQ;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= RADDR;
                        end
                    end
                end
                RADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RDATA;
                    end
                end
                RDATA: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rdata_out <= rdata;
                        state     <= DONE;
                    end
                end
                WREQ: begin
                    // A deasserted valid means that channel already handshook.
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
                        state  <= WRESP;
                    end
                end
                WRESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRIDGE_ERR_LATCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err  <= 1'b0;
            err_addr <= 32'h0;
        end else if (!bus_err && ((rready && rvalid && rresp != 2'b00) ||
                                  (bready && bvalid && bresp != 2'b00))) begin
            bus_err  <= 1'b1;
            err_addr <= addr_q;
        end
    end
`else
    logic unused_resp;
    assign unused_resp = &{1'b0, rresp, bresp};
`endif

endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb/tb_cache_axi_bridge.sv - directed self-checking bench for cache_axi_bridge

`ifndef CACHE_TYPE_BITS
`define CACHE_TYPE_BITS 3
`endif
`ifndef CACHE_BYTE
`define CACHE_BYTE    3'd0
`endif
`ifndef CACHE_HWORD
`define CACHE_HWORD   3'd1
`endif
`ifndef CACHE_WORD
`define CACHE_WORD    3'd2
`endif
`ifndef CACHE_BYTE_U
`define CACHE_BYTE_U  3'd3
`endif
`ifndef CACHE_HWORD_U
`define CACHE_HWORD_U 3'd4
`endif

module tb_cache_axi_bridge;

    logic        clk = 1'b0;
    logic        rst, req, write;
    logic [31:0] addr, wdata_in;
    logic [`CACHE_TYPE_BITS-1:0] cache_type;
    logic [31:0] rdata_out;
    logic        wait_o;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
`ifdef BRIDGE_ERR_LATCH_EN
    logic        bus_err;
    logic [31:0] err_addr;
`endif

    int checks = 0;
    int fails  = 0;

    logic [31:0]                 t_addr [4] = '{32'h0000_2006, 32'h0000_2004, 32'h0000_2001, 32'h0000_2002};
    logic [`CACHE_TYPE_BITS-1:0] t_type [4] = '{`CACHE_HWORD, `CACHE_WORD, `CACHE_BYTE, `CACHE_BYTE_U};
    logic [3:0]                  t_strb [4] = '{4'b1100, 4'b1111, 4'b0010, 4'b0000};
    logic [2:0]                  t_size [4] = '{3'd1, 3'd2, 3'd0, 3'd2};

    cache_axi_bridge dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .write(write),
        .wdata_in(wdata_in), .cache_type(cache_type),
        .rdata_out(rdata_out), .wait_o(wait_o),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef BRIDGE_ERR_LATCH_EN
        , .bus_err(bus_err), .err_addr(err_addr)
`endif
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task idle_inputs;
        req = 0; addr = 0; write = 0; wdata_in = 0; cache_type = `CACHE_WORD;
        arready = 0; rdata = 0; rresp = 0; rvalid = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
    endtask

    task test_reset;
        idle_inputs();
        rst = 1; req = 1;
        #12;
        checks++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin fails++; $display("FAIL reset_handshakes: got %b expected 00000", {arvalid, rready, awvalid, wvalid, bready}); end
        checks++; if (rdata_out !== 32'h0) begin fails++; $display("FAIL reset_rdata_out: got %h expected 00000000", rdata_out); end
        checks++; if (wait_o !== 1'b0) begin fails++; $display("FAIL reset_wait_o: got %b expected 0", wait_o); end
`ifdef BRIDGE_ERR_LATCH_EN
        checks++; if ({bus_err, err_addr} !== 33'h0) begin fails++; $display("FAIL reset_err: got %b %h expected 0 00000000", bus_err, err_addr); end
`endif
        req = 0;
        @(negedge clk);
        rst = 0;
        tick();
    endtask

    task test_load;
        req = 1; addr = 32'h0000_1008; write = 0; arready = 1;
        #1;
        checks++; if (wait_o !== 1'b1) begin fails++; $display("FAIL load_wait_idle_req: got %b expected 1", wait_o); end
        tick();
        checks++; if ({arvalid, araddr, arsize} !== {1'b1, 32'h0000_1008, 3'd2}) begin fails++; $display("FAIL load_ar: got %b %h %0d expected 1 00001008 2", arvalid, araddr, arsize); end
        checks++; if (wait_o !== 1'b1) begin fails++; $display("FAIL load_wait_raddr: got %b expected 1", wait_o); end
        req = 0;
        tick();
        checks++; if ({rready, arvalid} !== 2'b10) begin fails++; $display("FAIL load_rdata_state: got rready=%b arvalid=%b expected 1 0", rready, arvalid); end
        rvalid = 1; rdata = 32'hDEAD_BEEF;
        tick();
        checks++; if ({wait_o, rdata_out} !== {1'b0, 32'hDEAD_BEEF}) begin fails++; $display("FAIL load_done: got wait_o=%b rdata_out=%h expected 0 deadbeef", wait_o, rdata_out); end
        rvalid = 0; rdata = 0; arready = 0;
        tick();
        checks++; if ({wait_o, rdata_out} !== {1'b0, 32'hDEAD_BEEF}) begin fails++; $display("FAIL load_hold: got wait_o=%b rdata_out=%h expected 0 deadbeef", wait_o, rdata_out); end
    endtask

    task test_store_byte;
        req = 1; addr = 32'h0000_2003; write = 1; wdata_in = 32'hAA00_0000;
        cache_type = `CACHE_BYTE; awready = 1; wready = 1;
        tick();
        checks++; if ({awvalid, wvalid, wlast, wait_o} !== 4'b1111) begin fails++; $display("FAIL byte_valids: got %b expected 1111", {awvalid, wvalid, wlast, wait_o}); end
        checks++; if ({awaddr, awsize, wstrb, wdata} !== {32'h0000_2003, 3'd0, 4'b1000, 32'hAA00_0000}) begin fails++; $display("FAIL byte_fields: got %h %0d %b %h expected 00002003 0 1000 aa000000", awaddr, awsize, wstrb, wdata); end
        req = 0; addr = 0; wdata_in = 0;
        tick();
        checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin fails++; $display("FAIL byte_wresp: got %b expected 001", {awvalid, wvalid, bready}); end
        bvalid = 1;
        tick();
        checks++; if ({wait_o, bready} !== 2'b00) begin fails++; $display("FAIL byte_done: got %b expected 00", {wait_o, bready}); end
        bvalid = 0; awready = 0; wready = 0;
        tick();
    endtask

    task test_store_table;
        awready = 1; wready = 1;
        for (int i = 0; i < 4; i++) begin
            req = 1; addr = t_addr[i]; write = 1; wdata_in = 32'h1122_3344; cache_type = t_type[i];
            tick();
            checks++; if (wstrb !== t_strb[i]) begin fails++; $display("FAIL table_wstrb[%0d]: got %b expected %b", i, wstrb, t_strb[i]); end
            if (i < 3) begin
                checks++; if (awsize !== t_size[i]) begin fails++; $display("FAIL table_awsize[%0d]: got %0d expected %0d", i, awsize, t_size[i]); end
            end
            req = 0; bvalid = 1;
            tick();
            tick();
            bvalid = 0;
            tick();
        end
        awready = 0; wready = 0;
    endtask

    task test_store_backpressure;
        req = 1; addr = 32'h0000_2008; write = 1; wdata_in = 32'h1234_5678;
        cache_type = `CACHE_WORD; awready = 0; wready = 1;
        tick();
        checks++; if ({awvalid, wvalid} !== 2'b11) begin fails++; $display("FAIL bp_first: got %b expected 11", {awvalid, wvalid}); end
        req = 0;
        tick();
        checks++; if ({awvalid, wvalid, bready, wait_o} !== 4'b1001) begin fails++; $display("FAIL bp_w_done: got %b expected 1001", {awvalid, wvalid, bready, wait_o}); end
        tick();
        checks++; if ({awvalid, wvalid, awaddr} !== {2'b10, 32'h0000_2008}) begin fails++; $display("FAIL bp_aw_held: got %b %h expected 10 00002008", {awvalid, wvalid}, awaddr); end
        awready = 1;
        tick();
        checks++; if ({awvalid, bready} !== 2'b01) begin fails++; $display("FAIL bp_aw_done: got %b expected 01", {awvalid, bready}); end
        awready = 0; wready = 0;
        tick();
        checks++; if ({bready, wait_o} !== 2'b11) begin fails++; $display("FAIL bp_wresp_wait: got %b expected 11", {bready, wait_o}); end
        bvalid = 1;
        tick();
        checks++; if ({wait_o, bready} !== 2'b00) begin fails++; $display("FAIL bp_done: got %b expected 00", {wait_o, bready}); end
        bvalid = 0; req = 1; addr = 32'h0000_2010; write = 0;
        tick();
        checks++; if ({wait_o, arvalid} !== 2'b10) begin fails++; $display("FAIL bp_single_done: got %b expected 10", {wait_o, arvalid}); end
        req = 0;
        tick();
    endtask

`ifdef BRIDGE_ERR_LATCH_EN
    task test_err_latch;
        req = 1; addr = 32'h0000_3000; write = 1; wdata_in = 32'h0; cache_type = `CACHE_WORD;
        awready = 1; wready = 1;
        tick();
        req = 0;
        tick();
        bvalid = 1; bresp = 2'b10;
        tick();
        checks++; if ({bus_err, err_addr} !== {1'b1, 32'h0000_3000}) begin fails++; $display("FAIL err_set: got %b %h expected 1 00003000", bus_err, err_addr); end
        bvalid = 0; bresp = 0; awready = 0; wready = 0;
        tick();
        req = 1; addr = 32'h0000_4000; write = 0; arready = 1;
        tick();
        req = 0;
        tick();
        rvalid = 1; rdata = 32'h1; rresp = 0;
        tick();
        rvalid = 0; arready = 0;
        tick();
        checks++; if ({bus_err, err_addr} !== {1'b1, 32'h0000_3000}) begin fails++; $display("FAIL err_retained: got %b %h expected 1 00003000", bus_err, err_addr); end
    endtask
`endif

    task test_ar_stall;
        req = 1; addr = 32'h0000_1010; write = 0; arready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            req = 0;
            checks++; if ({arvalid, araddr, wait_o} !== {1'b1, 32'h0000_1010, 1'b1}) begin fails++; $display("FAIL stall_cycle%0d: got %b %h %b expected 1 00001010 1", i, arvalid, araddr, wait_o); end
        end
        arready = 1;
        tick();
        checks++; if ({rready, arvalid} !== 2'b10) begin fails++; $display("FAIL stall_rdata: got %b expected 10", {rready, arvalid}); end
        rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 2'b10;
        tick();
        checks++; if ({wait_o, rdata_out} !== {1'b0, 32'hCAFE_F00D}) begin fails++; $display("FAIL stall_slverr_done: got %b %h expected 0 cafef00d", wait_o, rdata_out); end
`ifdef BRIDGE_ERR_LATCH_EN
        checks++; if ({bus_err, err_addr} !== {1'b1, 32'h0000_3000}) begin fails++; $display("FAIL err_first_only: got %b %h expected 1 00003000", bus_err, err_addr); end
`endif
        rvalid = 0; rresp = 0; arready = 0;
        tick();
    endtask

    task test_rst_mid;
        req = 1; addr = 32'h0000_1020; write = 0; arready = 1;
        tick();
        req = 0;
        tick();
        checks++; if (rready !== 1'b1) begin fails++; $display("FAIL rstmid_in_rdata: got %b expected 1", rready); end
        req = 1; rst = 1;
        #1;
        checks++; if ({rready, arvalid, wait_o} !== 3'b000) begin fails++; $display("FAIL rstmid_abort: got %b expected 000", {rready, arvalid, wait_o}); end
        checks++; if (rdata_out !== 32'h0) begin fails++; $display("FAIL rstmid_rdata_out: got %h expected 00000000", rdata_out); end
`ifdef BRIDGE_ERR_LATCH_EN
        checks++; if (bus_err !== 1'b0) begin fails++; $display("FAIL rstmid_bus_err: got %b expected 0", bus_err); end
`endif
        tick();
        rst = 0; addr = 32'h0000_1024;
        #1;
        checks++; if (wait_o !== 1'b1) begin fails++; $display("FAIL rstmid_new_wait: got %b expected 1", wait_o); end
        tick();
        checks++; if ({arvalid, araddr} !== {1'b1, 32'h0000_1024}) begin fails++; $display("FAIL rstmid_new_ar: got %b %h expected 1 00001024", arvalid, araddr); end
        req = 0;
        tick();
        rvalid = 1; rdata = 32'h5A5A_1234;
        tick();
        checks++; if ({wait_o, rdata_out} !== {1'b0, 32'h5A5A_1234}) begin fails++; $display("FAIL rstmid_new_done: got %b %h expected 0 5a5a1234", wait_o, rdata_out); end
        rvalid = 0; arready = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_byte();
        test_store_table();
        test_store_backpressure();
`ifdef BRIDGE_ERR_LATCH_EN
        test_err_latch();
`endif
        test_ar_stall();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
